logic_sweep_ctrl: RTL
=====================

# logic_sweep_ctrl

Sequencing controller that exhaustively exercises a 4-input combinational function block (inputs W, X, Y, Z; output G). On `start` it walks all 16 input vectors, holds each for a programmable settle time and samples G. It assembles the 16-bit truth table, counts its ones and compares it against an expected mask. It sits beside the function block, drives its inputs and reads its output, and is used for self-check of the logic-design exercise blocks.

## Interface
- `SETTLE`, 1: cycles each vector is held before G is sampled; legal 1..15.
- `EXPECT`, 16'h131F: expected truth table; bit m = G for minterm m = {W,X,Y,Z}, W is the MSB.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a sweep; sampled only in IDLE.
- `abort`  in  1  cancel the sweep in progress.
- `vec_w`, `vec_x`, `vec_y`, `vec_z`  out  1 each  drive the function block's W, X, Y, Z.
- `g_in`  in  1  the function block's G output.
- `busy`  out  1  high during SWEEP.
- `done`  out  1  one-cycle pulse when results are valid.
- `table_out`  out  16  last completed truth table.
- `ones`  out  5  popcount of `table_out`, 0..16.
- `match`  out  1  `table_out == EXPECT`.

## Operation
- FSM states: IDLE, SWEEP, DONE.
- IDLE -> SWEEP on `start` with `abort` low.
  - On entry: step index k=0, settle counter=SETTLE, shadow table cleared, vector = seq(0).
- SWEEP:
  - Settle counter decrements each cycle.
  - When it reaches 1 at an edge, `g_in` is written into shadow bit seq(k) at that edge.
  - At the same edge, if k<15: k increments, the vector advances to seq(k+1) and the counter reloads to SETTLE.
  - If k==15: go to DONE.
- DONE (exactly one cycle):
  - `done`=1.
  - `table_out`, `ones` and `match` load atomically from the shadow table.
  - Next state is IDLE.
- `abort` in SWEEP -> IDLE at the next edge.
  - No `done` pulse.
  - `table_out`, `ones` and `match` keep their previous values.
  - Shadow contents are discarded.
- `start` in SWEEP or DONE: ignored, not queued.
- `start` and `abort` together in IDLE: `abort` wins; the FSM stays in IDLE.
- Vector outputs are 0 in IDLE and DONE.
- `ones` is a 5-bit popcount; the value 16 must be representable, so there is no wrap.
- `match` is computed from the registered result, not from the shadow table.

## Timing
- Reset (`rst_n` low at an edge): state=IDLE; all outputs 0, including `table_out`=16'h0000, `ones`=0 and `match`=0.
- Reset has priority over `start`/`abort` and takes effect from any state, including mid-sweep.
- `start` sampled at edge E0:
  - `busy`=1 and vector=seq(0) from E0.
  - Vector j is applied from edge E0+j·SETTLE.
  - Vector j is sampled at edge E0+(j+1)·SETTLE.
- After the final sample at E0+16·SETTLE: `busy`=0 and `done`=1 for the following cycle, with results valid in that same cycle.
- Back in IDLE one cycle later; the earliest new `start` is accepted in the cycle after `done`.
- Sweep latency, `start` edge to the `done` cycle: 16·SETTLE+1 cycles.
- `g_in` must be stable at least one cycle after each vector change; this is guaranteed by SETTLE≥1 when the function block is purely combinational.

## Configuration
- `LOGIC_SWEEP_GRAY_EN`:
  - Defined: seq(k) = k ^ (k>>1), i.e. Gray order 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8. Only one input toggles per step.
  - Undefined: seq(k) = k, i.e. binary order 0..15.
- In both builds, table bit index = the minterm value seq(k), so `table_out`, `ones` and `match` are identical for the same function.

## Test plan
- SETTLE=1, function block W,X,Y,Z -> G connected, `start` pulse:
  - `done` exactly 17 cycles after the `start` edge.
  - `table_out`=16'h131F, `ones`=8, `match`=1.
- Binary and Gray builds:
  - Monitor `{vec_w,vec_x,vec_y,vec_z}` per step: binary gives 0,1,2,…,15; Gray gives 0,1,3,2,6,…,8.
  - Gray build: exactly one input toggles per step.
  - Final `table_out`=16'h131F in both builds.
- `g_in` tied 1, SETTLE=3:
  - `done` at 49 cycles after `start`.
  - `table_out`=16'hFFFF, `ones`=16, `match`=0.
- After a good sweep (16'h131F):
  - `start` again, then `abort` at cycle 5: `busy` drops next edge, no `done`, `table_out` still 16'h131F.
  - `start`+`abort` together in IDLE: no sweep.
- `start` pulsed while `busy`: ignored; only one `done` occurs, at the original latency.
- `rst_n` low for one cycle mid-sweep (step 7): next cycle IDLE, all outputs 0, no `done`; a new `start` completes normally.

Source files
------------

// File: rtl/logic_sweep_ctrl.sv
// logic_sweep_ctrl
// Drives all 16 input vectors into a 4-input combinational block and samples
// its output G. It builds the truth table, counts its ones and compares the
// result against an expected mask.
//
// Build option: define LOGIC_SWEEP_GRAY_EN to walk the vectors in Gray order,
// so that only one input toggles per step. By default the order is binary.
// Either way, each sampled bit lands at the index of its minterm, so the
// results do not depend on the walk order.

module logic_sweep_ctrl #(
    parameter int          SETTLE = 1,         // hold cycles per vector, 1..15
    parameter logic [15:0] EXPECT = 16'h131F   // expected truth table
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic        vec_w,
    output logic        vec_x,
    output logic        vec_y,
    output logic        vec_z,
    input  logic        g_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic [4:0]  ones,
    output logic        match
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    // Maps a step index onto the minterm that is applied at that step.
    function automatic logic [3:0] seq_of(input logic [3:0] k);
`ifdef LOGIC_SWEEP_GRAY_EN
        return k ^ (k >> 1);
`else
        return k;
`endif
    endfunction

    // Number of ones in a 16-bit table. The result is 5 bits wide so that
    // an all-ones table reports 16 instead of wrapping to 0.
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] sum;
        sum = '0;
        for (int i = 0; i < 16; i++) begin
            sum = sum + {4'd0, v[i]};
        end
        return sum;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  k_q, k_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] shadow_q, shadow_d;
    logic [3:0]  vec_q, vec_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] table_q, table_d;
    logic [4:0]  ones_q, ones_d;
    logic        match_q, match_d;
    logic [3:0]  seq_cur;
    logic [3:0]  seq_nxt;

    // Next-state logic. The shadow table fills up while the sweep runs.
    // The visible results are overwritten only on the edge that enters
    // DONE, so an abort leaves the previous results untouched.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        vec_d    = vec_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        table_d  = table_q;
        ones_d   = ones_q;
        match_d  = match_q;
        seq_cur  = seq_of(k_q);
        seq_nxt  = seq_of(k_q + 4'd1);

        case (state_q)
            ST_IDLE: begin
                vec_d  = 4'd0;
                busy_d = 1'b0;
                if (start && !abort) begin
                    state_d  = ST_SWEEP;
                    k_d      = 4'd0;
                    cnt_d    = SETTLE_L;
                    shadow_d = 16'h0000;
                    vec_d    = seq_of(4'd0);
                    busy_d   = 1'b1;
                end
            end

            ST_SWEEP: begin
                if (abort) begin
                    state_d  = ST_IDLE;
                    busy_d   = 1'b0;
                    vec_d    = 4'd0;
                    shadow_d = 16'h0000;
                end else if (cnt_q <= 4'd1) begin
                    // The vector has been held for SETTLE cycles, so G
                    // is captured at this edge.
                    shadow_d[seq_cur] = g_in;
                    if (k_q != 4'd15) begin
                        k_d   = k_q + 4'd1;
                        vec_d = seq_nxt;
                        cnt_d = SETTLE_L;
                    end else begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        vec_d   = 4'd0;
                        done_d  = 1'b1;
                        table_d = shadow_d;
                        ones_d  = popcount16(shadow_d);
                        match_d = (shadow_d == EXPECT);
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                vec_d   = 4'd0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                vec_d   = 4'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset clears every output, including
    // the last truth table, and takes priority over start and abort.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            k_q      <= 4'd0;
            cnt_q    <= 4'd0;
            shadow_q <= 16'h0000;
            vec_q    <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            table_q  <= 16'h0000;
            ones_q   <= 5'd0;
            match_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            vec_q    <= vec_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            table_q  <= table_d;
            ones_q   <= ones_d;
            match_q  <= match_d;
        end
    end

    assign vec_w     = vec_q[3];
    assign vec_x     = vec_q[2];
    assign vec_y     = vec_q[1];
    assign vec_z     = vec_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign table_out = table_q;
    assign ones      = ones_q;
    assign match     = match_q;

endmodule
